// File: rtl/ppu_oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// ppu_pkg: shared definitions for the PPU register-port side of the CPU bus.
//
// Contents:
//   ppu_dma_state_t  - OAM DMA sequencer states
//   PPU_REG_OAMDATA  - PPU register select for OAMDATA ($2004)
//   PPU_RW_READ/WRITE- encoding of the PPU rw line (1 = write)
//   OAM_DMA_REG_ADDR - CPU address of the OAMDMA trigger register, for the
//                      bus decoder that generates reg_wr
// -----------------------------------------------------------------------------
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } ppu_dma_state_t;

  localparam logic [2:0]  PPU_REG_OAMDATA  = 3'h4;
  localparam logic        PPU_RW_READ      = 1'b0;
  localparam logic        PPU_RW_WRITE     = 1'b1;
  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;

endpackage

// File: rtl/ppu_oam_dma_if.sv
// -----------------------------------------------------------------------------
// ppu_oam_dma_if: bus bundle between the OAM DMA initiator and its targets.
//
// Signals:
//   mem_addr, mem_rd, mem_rdata  - CPU memory read port (DMA is the requester)
//   ppu_cs_n, ppu_addr, ppu_rw,
//   ppu_data_out, ppu_data_oe    - PPU register port (DMA is the bus master)
//
// Modports:
//   master - the DMA engine: drives addresses/strobes/data, receives mem_rdata
//   slave  - memory + PPU side: receives strobes, returns mem_rdata
// -----------------------------------------------------------------------------
interface ppu_oam_dma_if;

  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        ppu_cs_n;
  logic [2:0]  ppu_addr;
  logic        ppu_rw;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_oe;

  modport master (
    output mem_addr, mem_rd,
    input  mem_rdata,
    output ppu_cs_n, ppu_addr, ppu_rw, ppu_data_out, ppu_data_oe
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_rdata,
    input  ppu_cs_n, ppu_addr, ppu_rw, ppu_data_out, ppu_data_oe
  );

endinterface

// File: rtl/ppu_oam_dma.sv
// -----------------------------------------------------------------------------
// ppu_oam_dma: $4014 OAMDMA sprite-page copy engine.
//
// A write of page P to $4014 halts the CPU, then alternates one READ CPU cycle
// (fetch $PPnn from CPU memory) with one WRITE CPU cycle (store the byte to the
// PPU OAMDATA register) until XFER_LEN bytes have moved.
//
// Ports:
//   clk, rst_n   - clock (shared with the PPU), async active-low reset
//   cpu_ce       - one-clk CPU cycle boundary strobe; the sequencer advances
//                  only on these edges (except the trigger, which is taken
//                  on any clk)
//   reg_wr       - CPU wrote $4014; reg_wdata carries the page number
//   cpu_rdy      - 0 halts the CPU while a transfer is in progress
//   dma_busy     - high from the accepted trigger until back in IDLE
//   dma_done     - one-clk pulse as the last OAMDATA write completes
//   bus          - memory read port and PPU register port (master side)
//
// Build option:
//   OAM_DMA_ALIGN_EN - when defined, a trigger whose HALT cycle ends on an odd
//                      CPU cycle inserts one extra ALIGN cycle (514 halted
//                      cycles instead of 513). When undefined, ALIGN is never
//                      entered and every transfer is 513 cycles.
//
// All outputs are registered from the next-state decode, so each state's bus
// drives are present for the whole CPU cycle that state occupies.
// -----------------------------------------------------------------------------
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int unsigned XFER_LEN    = 256,
  parameter logic [2:0]  OAMDATA_REG = PPU_REG_OAMDATA
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_ce,
  input  logic          reg_wr,
  input  logic [7:0]    reg_wdata,
  output logic          cpu_rdy,
  output logic          dma_busy,
  output logic          dma_done,
  ppu_oam_dma_if.master bus
);

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_HALT  = 3'(HALT);
  localparam logic [2:0] ST_ALIGN = 3'(ALIGN);
  localparam logic [2:0] ST_READ  = 3'(READ);
  localparam logic [2:0] ST_WRITE = 3'(WRITE);

  localparam logic [8:0] LAST_CNT = 9'(XFER_LEN - 1);

  logic [2:0] state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic [7:0] page, page_nxt;
  logic       odd;
  logic       last_edge;
  logic       rd_nxt, wr_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    page_nxt  = page;
    last_edge = 1'b0;
    case (state)
      // The trigger is a one-clk strobe, so it is taken on any clk, not only
      // on a CPU cycle boundary.
      ST_IDLE: begin
        if (reg_wr) begin
          state_nxt = ST_HALT;
          page_nxt  = reg_wdata;
          cnt_nxt   = '0;
        end
      end
      // odd is sampled before this edge toggles it: it is the parity of the
      // CPU cycle that is ending.
      ST_HALT: begin
        if (cpu_ce) state_nxt = (ALIGN_EN && odd) ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        if (cpu_ce) state_nxt = ST_READ;
      end
      ST_READ: begin
        if (cpu_ce) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (cpu_ce) begin
          cnt_nxt = cnt + 9'd1;
          if (cnt == LAST_CNT) begin
            last_edge = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_nxt = (state_nxt == ST_READ);
  assign wr_nxt = (state_nxt == ST_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      page              <= '0;
      odd               <= 1'b0;
      cpu_rdy           <= 1'b1;
      dma_busy          <= 1'b0;
      dma_done          <= 1'b0;
      bus.mem_rd        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.ppu_cs_n      <= 1'b1;
      bus.ppu_addr      <= '0;
      bus.ppu_rw        <= PPU_RW_READ;
      bus.ppu_data_out  <= '0;
      bus.ppu_data_oe   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      page     <= page_nxt;
      if (cpu_ce) odd <= ~odd;

      cpu_rdy  <= (state_nxt == ST_IDLE);
      dma_busy <= (state_nxt != ST_IDLE);
      dma_done <= last_edge;

      // Low byte comes from the counter only; the page never takes a carry.
      bus.mem_rd   <= rd_nxt;
      bus.mem_addr <= rd_nxt ? {page_nxt, cnt_nxt[7:0]} : '0;

      // cs is low for exactly the WRITE cycle and high for the READ cycle
      // before it, giving one falling edge per byte at the PPU.
      bus.ppu_cs_n    <= ~wr_nxt;
      bus.ppu_addr    <= wr_nxt ? OAMDATA_REG : 3'h0;
      bus.ppu_rw      <= wr_nxt ? PPU_RW_WRITE : PPU_RW_READ;
      bus.ppu_data_oe <= wr_nxt;

      // The output data register doubles as the capture register: memory
      // data is valid on the edge that ends READ and enters WRITE.
      if (!wr_nxt) begin
        bus.ppu_data_out <= '0;
      end else if (state == ST_READ) begin
        bus.ppu_data_out <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_ppu_oam_dma: bench for ppu_oam_dma.
//
// Two instances share clk/rst_n/cpu_ce: u0 with the full 256-byte transfer and
// u1 with a 4-byte transfer. A transfer-level reference model (position within
// the transfer counted in CPU cycles) predicts every output each clk; directed
// scenarios plus a randomized phase drive the triggers and CPU cycle pacing.
// Honours OAM_DMA_ALIGN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_ppu_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_ce;
  logic       reg_wr0, reg_wr1;
  logic [7:0] wdata0, wdata1;
  logic       rdy0, rdy1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  ppu_oam_dma_if bus0 ();
  ppu_oam_dma_if bus1 ();

  logic [7:0] mem [0:65535];
  assign bus0.mem_rdata = mem[bus0.mem_addr];
  assign bus1.mem_rdata = mem[bus1.mem_addr];

  ppu_oam_dma #(.XFER_LEN(256)) u0 (
    .clk(clk), .rst_n(rst_n), .cpu_ce(cpu_ce), .reg_wr(reg_wr0),
    .reg_wdata(wdata0), .cpu_rdy(rdy0), .dma_busy(busy0),
    .dma_done(done0), .bus(bus0)
  );

  ppu_oam_dma #(.XFER_LEN(4)) u1 (
    .clk(clk), .rst_n(rst_n), .cpu_ce(cpu_ce), .reg_wr(reg_wr1),
    .reg_wdata(wdata1), .cpu_rdy(rdy1), .dma_busy(busy1),
    .dma_done(done1), .bus(bus1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // CPU cycle pacing: period N>0 gives cpu_ce every N clks, 0 gives random.
  int ce_period = 3;
  int ce_ph     = 0;
  int ce_edges  = 0;
  bit ce_run    = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!ce_run) begin
      cpu_ce = 1'b0;
      ce_ph  = 0;
    end else begin
      if (ce_period == 0) cpu_ce = ($urandom_range(0, 1) == 1);
      else                cpu_ce = (ce_ph == 0);
      ce_ph = ce_ph + 1;
      if (ce_ph >= ce_period) ce_ph = 0;
      if (cpu_ce) ce_edges++;
    end
  end

  // Reference model, one slot per instance. m_k counts CPU cycles elapsed
  // since the HALT cycle ended; the transfer spans 2*len (+1 if aligned).
  int         m_len   [2] = '{256, 4};
  bit         m_busy  [2];
  bit         m_halt  [2];
  bit         m_align [2];
  bit         m_done  [2];
  bit         m_par   [2];
  int         m_k     [2];
  logic [7:0] m_page  [2];

  // Observed-event statistics.
  int          wcount  [2];
  int          dcount  [2];
  int          halted  [2];
  int          b2b     [2];
  logic [15:0] maxaddr [2];
  logic [15:0] first_a [2];
  bit          got_first [2];
  bit          prev_cs [2];
  logic [7:0]  wlog [0:255];

  task automatic stats_reset();
    for (int i = 0; i < 2; i++) begin
      wcount[i] = 0; dcount[i] = 0; halted[i] = 0; b2b[i] = 0;
      maxaddr[i] = '0; first_a[i] = '0; got_first[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic cs_n, mrd, rdy, busy, done, rw, oe, r_wr, is_rd, is_wr;
      logic [15:0] maddr, ea;
      logic [2:0]  paddr;
      logic [7:0]  pdata, r_wd;
      int j;
      if (i == 0) begin
        cs_n = bus0.ppu_cs_n; mrd = bus0.mem_rd; maddr = bus0.mem_addr;
        paddr = bus0.ppu_addr; rw = bus0.ppu_rw; oe = bus0.ppu_data_oe;
        pdata = bus0.ppu_data_out; rdy = rdy0; busy = busy0; done = done0;
        r_wr = reg_wr0; r_wd = wdata0;
      end else begin
        cs_n = bus1.ppu_cs_n; mrd = bus1.mem_rd; maddr = bus1.mem_addr;
        paddr = bus1.ppu_addr; rw = bus1.ppu_rw; oe = bus1.ppu_data_oe;
        pdata = bus1.ppu_data_out; rdy = rdy1; busy = busy1; done = done1;
        r_wr = reg_wr1; r_wd = wdata1;
      end

      if (!rst_n) begin
        m_busy[i] = 1'b0; m_halt[i] = 1'b0; m_align[i] = 1'b0;
        m_done[i] = 1'b0; m_par[i] = 1'b0;  m_k[i] = 0;
        prev_cs[i] = 1'b1;
      end else begin
        j     = m_k[i] - int'(m_align[i]);
        is_rd = m_busy[i] && !m_halt[i] && (j >= 0) && (j % 2 == 0);
        is_wr = m_busy[i] && !m_halt[i] && (j >= 0) && (j % 2 == 1);
        ea    = {m_page[i], 8'(j / 2)};

        chk($sformatf("u%0d_cpu_rdy", i), rdy, !m_busy[i]);
        chk($sformatf("u%0d_dma_busy", i), busy, m_busy[i]);
        chk($sformatf("u%0d_dma_done", i), done, m_done[i]);
        chk($sformatf("u%0d_mem_rd", i), mrd, is_rd);
        chk($sformatf("u%0d_ppu_cs_n", i), cs_n, !is_wr);
        if (is_rd) chk($sformatf("u%0d_mem_addr", i), maddr, ea);
        if (is_wr) begin
          chk($sformatf("u%0d_ppu_addr", i), paddr, 3'h4);
          chk($sformatf("u%0d_ppu_rw", i), rw, 1'b1);
          chk($sformatf("u%0d_ppu_oe", i), oe, 1'b1);
          chk($sformatf("u%0d_ppu_data", i), pdata, mem[ea]);
        end

        if (prev_cs[i] && !cs_n) begin
          if (i == 0 && wcount[0] < 256) wlog[wcount[0]] = pdata;
          wcount[i]++;
        end
        if (!prev_cs[i] && !cs_n) b2b[i]++;
        prev_cs[i] = cs_n;
        if (done) dcount[i]++;
        if (mrd && !got_first[i]) begin first_a[i] = maddr; got_first[i] = 1'b1; end
        if (mrd && maddr > maxaddr[i]) maxaddr[i] = maddr;
        if (cpu_ce && !rdy) halted[i]++;

        // Advance the model across the coming clk edge.
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          if (cpu_ce) begin
            if (m_halt[i]) begin
              m_halt[i]  = 1'b0;
              m_align[i] = ALIGN_EN && m_par[i];
              m_k[i]     = 0;
            end else begin
              m_k[i]++;
              if (m_k[i] == 2 * m_len[i] + int'(m_align[i])) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
              end
            end
          end
        end else if (r_wr) begin
          m_busy[i] = 1'b1;
          m_halt[i] = 1'b1;
          m_page[i] = r_wd;
        end
        if (cpu_ce) m_par[i] = ~m_par[i];
      end
    end
  end

  // Trigger a transfer. want_odd selects the parity of the CPU cycle that the
  // HALT cycle will end on (needs ce_period >= 2); -1 means any.
  task automatic issue(input int inst, input logic [7:0] pg, input int want_odd);
    int guard = 0;
    while (!(want_odd < 0 || (!cpu_ce && (ce_edges % 2) == want_odd)) && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 100) chk("issue_parity_timeout", 0, 1);
    if (inst == 0) begin reg_wr0 = 1'b1; wdata0 = pg; end
    else           begin reg_wr1 = 1'b1; wdata1 = pg; end
    @(posedge clk); #2;
    reg_wr0 = 1'b0;
    reg_wr1 = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int limit);
    int n = 0;
    while (m_busy[inst] && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    if (m_busy[inst]) chk("wait_idle_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_writes(input int cnt, input int limit);
    int n = 0;
    while (wcount[0] < cnt && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    if (wcount[0] < cnt) chk("wait_writes_timeout", 0, 1);
  endtask

  task automatic do_reset();
    ce_run = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    ce_edges = 0;
    ce_run   = 1'b1;
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 256; a++) mem[16'h0200 + a] = 8'(a) ^ 8'h5A;
    rst_n = 1'b0; reg_wr0 = 1'b0; reg_wr1 = 1'b0; wdata0 = '0; wdata1 = '0;
    cpu_ce = 1'b0;
    stats_reset();

    // Reset state
    ce_period = 3;
    do_reset();
    #1;
    chk("rst_cpu_rdy", rdy0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_cs_n", bus0.ppu_cs_n, 1'b1);
    chk("rst_mem_rd", bus0.mem_rd, 1'b0);
    chk("rst_mem_addr", bus0.mem_addr, 16'h0000);
    chk("rst_ppu_addr", bus0.ppu_addr, 3'h0);
    chk("rst_ppu_rw", bus0.ppu_rw, 1'b0);
    chk("rst_data_out", bus0.ppu_data_out, 8'h00);
    chk("rst_data_oe", bus0.ppu_data_oe, 1'b0);

    // Basic copy, trigger so HALT ends on an even cycle
    stats_reset();
    issue(0, 8'h02, 0);
    wait_idle(0, 4000);
    chk("basic_writes", wcount[0], 256);
    chk("basic_done", dcount[0], 1);
    chk("basic_halted", halted[0], 513);
    chk("basic_byte0", wlog[0], 8'h5A);
    chk("basic_byte1", wlog[1], 8'h5B);
    chk("basic_byte255", wlog[255], 8'hA5);
    chk("basic_first_addr", first_a[0], 16'h0200);
    chk("basic_max_addr", maxaddr[0], 16'h02FF);

    // Odd alignment
    stats_reset();
    issue(0, 8'h02, 1);
    wait_idle(0, 4000);
    chk("odd_halted", halted[0], ALIGN_EN ? 514 : 513);
    chk("odd_first_addr", first_a[0], 16'h0200);
    chk("odd_writes", wcount[0], 256);

    // Busy rejection
    ce_period = 2;
    stats_reset();
    issue(0, 8'h02, -1);
    wait_writes(100, 3000);
    reg_wr0 = 1'b1; wdata0 = 8'h07;
    @(posedge clk); #2;
    reg_wr0 = 1'b0;
    wait_idle(0, 4000);
    chk("busy_writes", wcount[0], 256);
    chk("busy_done", dcount[0], 1);
    chk("busy_max_addr", maxaddr[0], 16'h02FF);
    chk("busy_byte100", wlog[100], 8'h3E);

    // Asynchronous reset in the WRITE of byte 37
    ce_period = 3;
    stats_reset();
    issue(0, 8'h02, -1);
    wait_writes(38, 3000);
    chk("prerst_cs_low", bus0.ppu_cs_n, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", bus0.ppu_cs_n, 1'b1);
    chk("arst_cpu_rdy", rdy0, 1'b1);
    chk("arst_busy", busy0, 1'b0);
    chk("arst_done", done0, 1'b0);
    ce_run = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; ce_edges = 0; ce_run = 1'b1;
    chk("arst_no_done", dcount[0], 0);
    stats_reset();
    issue(0, 8'h03, -1);
    wait_idle(0, 4000);
    chk("after_rst_writes", wcount[0], 256);
    chk("after_rst_done", dcount[0], 1);
    chk("after_rst_first", first_a[0], 16'h0300);
    chk("after_rst_max", maxaddr[0], 16'h03FF);

    // Short transfer on the 4-byte instance
    ce_period = 2;
    stats_reset();
    issue(1, 8'hFF, -1);
    wait_idle(1, 200);
    chk("short_writes", wcount[1], 4);
    chk("short_done", dcount[1], 1);
    chk("short_first", first_a[1], 16'hFF00);
    chk("short_max", maxaddr[1], 16'hFF03);
    chk("short_halted", halted[1], 9 + int'(m_align[1]));

    // cs spacing with a CPU cycle every clk
    ce_period = 1;
    stats_reset();
    issue(0, 8'h02, -1);
    wait_idle(0, 2000);
    chk("fast_writes", wcount[0], 256);
    chk("fast_done", dcount[0], 1);
    chk("fast_back_to_back_low", b2b[0], 0);
    chk("fast_halted", halted[0], 513 + int'(m_align[0]));

    // Trigger coincident with the final WRITE edge is ignored
    ce_period = 2;
    stats_reset();
    issue(0, 8'h02, -1);
    n = 0;
    while (!(m_busy[0] && !m_halt[0] && m_k[0] == 511 + int'(m_align[0]) && cpu_ce)
           && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 3000) chk("final_edge_timeout", 0, 1);
    reg_wr0 = 1'b1; wdata0 = 8'h07;
    @(posedge clk); #2;
    reg_wr0 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("final_edge_busy", busy0, 1'b0);
    chk("final_edge_rdy", rdy0, 1'b1);
    chk("final_edge_done", dcount[0], 1);

    // Randomized triggers and CPU cycle pacing
    stats_reset();
    for (int blk = 0; blk < 6; blk++) begin
      ce_period = $urandom_range(0, 4);
      for (int c = 0; c < 600; c++) begin
        reg_wr0 = ($urandom_range(0, 49) == 0); wdata0 = 8'($urandom);
        reg_wr1 = ($urandom_range(0, 29) == 0); wdata1 = 8'($urandom);
        @(posedge clk); #2;
      end
    end
    reg_wr0 = 1'b0;
    reg_wr1 = 1'b0;
    wait_idle(0, 6000);
    wait_idle(1, 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
